// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: FSM states, rate table and pad constants used by
// the padder, the Keccak core and the output serialiser.
package sha3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_PADBLK = 2'd2,
      ST_EMIT   = 2'd3
   } sha3_state_e;

   localparam int MAX_RATE       = 1152;
   localparam int MAX_RATE_BYTES = MAX_RATE / 8;

   // Domain-separation byte (SHA-3 suffix 01 + first pad bit) and final pad bit.
   localparam logic [7:0] PAD_DOMAIN = 8'h06;
   localparam logic [7:0] PAD_FINAL  = 8'h80;

   // Rate in bits, indexed by TID: SHA3-224, -256, -384, -512.
   localparam logic [3:0][10:0] RATE_BITS = {11'd576, 11'd832, 11'd1088, 11'd1152};

endpackage

// File: rtl/sha3_padder_if.sv
// Stream-in / block-out bundle of the SHA-3 padder.
// master = upstream source + block consumer, slave = the padder.
interface sha3_padder_if #(parameter int DATA_WIDTH = 16) ();
   import sha3_pkg::*;

   logic [DATA_WIDTH-1:0]   S_TDATA;
   logic                    S_TVALID;
   logic                    S_TREADY;
   logic                    S_TLAST;
   logic [DATA_WIDTH/8-1:0] S_TKEEP;
   logic [1:0]              S_TID;

   logic [MAX_RATE-1:0]     Blk_data;
   logic                    Blk_valid;
   logic                    Blk_ready;
   logic                    Blk_first;
   logic                    Blk_last;
   logic [1:0]              Blk_tid;

   modport master (
      output S_TDATA, S_TVALID, S_TLAST, S_TKEEP, S_TID, Blk_ready,
      input  S_TREADY, Blk_data, Blk_valid, Blk_first, Blk_last, Blk_tid
   );

   modport slave (
      input  S_TDATA, S_TVALID, S_TLAST, S_TKEEP, S_TID, Blk_ready,
      output S_TREADY, Blk_data, Blk_valid, Blk_first, Blk_last, Blk_tid
   );

endinterface

// File: rtl/sha3_pad_gen.sv
// Combinational pad10*1 insertion: keeps bytes below n, puts 0x06 at byte n,
// ORs 0x80 into the last rate byte and clears everything else.
module sha3_pad_gen
   import sha3_pkg::*;
(
   input  logic [MAX_RATE-1:0] blk_i,
   input  logic [7:0]          n_i,
   input  logic [7:0]          rate_bytes_i,
   output logic [MAX_RATE-1:0] blk_o
);

   // Per-byte select; when n == rate-1 the two pad bytes merge into 0x86.
   always_comb begin
      blk_o = '0;
      for (int b = 0; b < MAX_RATE_BYTES; b++) begin
         if (8'(b) < n_i)
            blk_o[8*b +: 8] = blk_i[8*b +: 8];
         if (8'(b) == n_i)
            blk_o[8*b +: 8] = blk_o[8*b +: 8] | PAD_DOMAIN;
         if (8'(b) == rate_bytes_i - 8'd1)
            blk_o[8*b +: 8] = blk_o[8*b +: 8] | PAD_FINAL;
         if (8'(b) >= rate_bytes_i)
            blk_o[8*b +: 8] = 8'h00;
      end
   end

endmodule

// File: rtl/sha3_padder.sv
// SHA-3 message padder: packs AXI-Stream beats into rate-sized blocks,
// applies pad10*1 with the SHA-3 domain suffix and hands blocks to Keccak.
module sha3_padder
   import sha3_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic          ACLK,
   input  logic          ARESET,
   sha3_padder_if.slave  bus
);

   localparam int BYTES = DATA_WIDTH / 8;

   sha3_state_e           state_q;
   logic [MAX_RATE-1:0]   buf_q, merged_d, pad_in_d, padded_d;
   logic [7:0]            wcnt_q, wnext_d, n_msg_d, pad_n_d;
   logic [7:0]            rate_bytes_d, rate_words_d;
   logic [3:0]            kcnt_d;
   logic [DATA_WIDTH-1:0] beat_d;
   logic [1:0]            tid_q, tid_d;
   logic                  rdy_q, vld_q, first_q, last_q, padpend_q, acc_d;

   // TID is taken live from the bus on the first beat, from the latch after.
   assign tid_d        = (state_q == ST_IDLE) ? bus.S_TID : tid_q;
   assign rate_bytes_d = RATE_BITS[tid_d][10:3];
   assign rate_words_d = 8'(RATE_BITS[tid_d] / 11'(DATA_WIDTH));
   assign acc_d        = bus.S_TVALID & rdy_q;
   assign wnext_d      = wcnt_q + 8'd1;
   assign n_msg_d      = 8'(int'(wcnt_q) * BYTES) + {4'd0, kcnt_d};

   // Mask the incoming beat by TKEEP (only on TLAST) and count its bytes.
   always_comb begin
      beat_d = '0;
      kcnt_d = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (!bus.S_TLAST || bus.S_TKEEP[i]) begin
            beat_d[8*i +: 8] = bus.S_TDATA[8*i +: 8];
            kcnt_d           = kcnt_d + 4'd1;
         end
      end
   end

   // Buffer with the current beat written at the word counter.
   always_comb begin
      merged_d = buf_q;
      merged_d[int'(wcnt_q)*DATA_WIDTH +: DATA_WIDTH] = beat_d;
   end

   // The pad-only block reuses the same pad generator with no message bytes.
   assign pad_in_d = (state_q == ST_PADBLK) ? '0   : merged_d;
   assign pad_n_d  = (state_q == ST_PADBLK) ? 8'd0 : n_msg_d;

   sha3_pad_gen u_pad_gen (
      .blk_i        (pad_in_d),
      .n_i          (pad_n_d),
      .rate_bytes_i (rate_bytes_d),
      .blk_o        (padded_d)
   );

   // Main FSM: fill, pad, and hold each block stable until the core takes it.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         buf_q     <= '0;
         wcnt_q    <= '0;
         tid_q     <= '0;
         rdy_q     <= 1'b0;
         vld_q     <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         padpend_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_FILL: begin
               rdy_q <= 1'b1;
               if (acc_d) begin
                  if (state_q == ST_IDLE) begin
                     tid_q   <= bus.S_TID;
                     first_q <= 1'b1;
                  end
                  if (bus.S_TLAST && n_msg_d != rate_bytes_d) begin
                     buf_q   <= padded_d;
                     last_q  <= 1'b1;
                     rdy_q   <= 1'b0;
                     vld_q   <= 1'b1;
                     state_q <= ST_EMIT;
                  end else if (bus.S_TLAST || wnext_d == rate_words_d) begin
                     // Full block; a TLAST here means a pad-only block follows.
                     buf_q     <= merged_d;
                     last_q    <= 1'b0;
                     padpend_q <= bus.S_TLAST;
                     rdy_q     <= 1'b0;
                     vld_q     <= 1'b1;
                     state_q   <= ST_EMIT;
                  end else begin
                     buf_q   <= merged_d;
                     wcnt_q  <= wnext_d;
                     state_q <= ST_FILL;
                  end
               end
            end
            ST_PADBLK: begin
               buf_q   <= padded_d;
               last_q  <= 1'b1;
               vld_q   <= 1'b1;
               state_q <= ST_EMIT;
            end
            ST_EMIT: begin
               if (bus.Blk_ready) begin
                  vld_q   <= 1'b0;
                  buf_q   <= '0;
                  wcnt_q  <= '0;
                  first_q <= 1'b0;
                  if (padpend_q) begin
                     padpend_q <= 1'b0;
                     state_q   <= ST_PADBLK;
                  end else if (last_q) begin
                     rdy_q   <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     rdy_q   <= 1'b1;
                     state_q <= ST_FILL;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.S_TREADY  = rdy_q;
   assign bus.Blk_valid = vld_q;
   assign bus.Blk_data  = buf_q;
   assign bus.Blk_first = first_q;
   assign bus.Blk_last  = last_q;
   assign bus.Blk_tid   = tid_q;

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 DATA_WIDTH, 16, input beat width in bits; SHALL be one of 8, 16, 32, 64.
REQ-002 ACLK  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 ARESET  input  1  synchronous, active-high reset.
REQ-004 S_TDATA  input  DATA_WIDTH  message bytes, little-endian (byte 0 in bits [7:0]).
REQ-005 S_TVALID / S_TREADY  input / output  1 each  AXI-Stream handshake; a beat transfers when both are high.
REQ-006 S_TLAST  input  1  marks the final beat of a message.
REQ-007 S_TKEEP  input  DATA_WIDTH/8  byte enables on the TLAST beat, contiguous from byte 0; all-zero means no bytes; ignored on non-last beats (treated as all-ones).
REQ-008 S_TID  input  2  variant: 0=SHA3-224, 1=-256, 2=-384, 3=-512; sampled on the first beat of a message only.
REQ-009 Blk_data  output  1152  rate block; word k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]; bits at and above the rate are zero.
REQ-010 Blk_valid / Blk_ready  output / input  1 each  block handshake to the Keccak permutation core.
REQ-011 Blk_first, Blk_last  output  1 each  first / final block of the message.
REQ-012 Blk_tid  output  2  latched S_TID, forwarded downstream to the squeeze/serialiser stage.

Function
REQ-013 Rate SHALL be 1152, 1088, 832 or 576 bits for TID 0..3; RATE_WORDS = rate/DATA_WIDTH.
REQ-014 States SHALL be IDLE, FILL, PADBLK, EMIT.
REQ-015 IDLE: S_TREADY=1; an accepted beat latches TID, is written to word 0 and moves to FILL; if that beat also has TLAST, go to EMIT.
REQ-016 FILL: S_TREADY=1; each accepted beat is written at the word counter, which then increments.
REQ-017 When the word counter reaches RATE_WORDS without TLAST, go to EMIT with Blk_last=0.
REQ-018 On a TLAST beat ending with n message bytes in the block (n < rate/8): byte n SHALL be ORed with 0x06, byte rate/8-1 ORed with 0x80, and all bytes above n up to rate/8-1 zeroed; go to EMIT with Blk_last=1.
REQ-019 If n = rate/8-1, that byte SHALL read 0x86.
REQ-020 If TLAST fills the block exactly (n = rate/8), emit that block with Blk_last=0 and, after its handshake, enter PADBLK.
REQ-021 PADBLK: lasts one cycle; loads a block of 0x06 at byte 0, 0x80 at byte rate/8-1 and zeros elsewhere; then EMIT with Blk_last=1, Blk_first=0.
REQ-022 EMIT: Blk_valid=1 and S_TREADY=0; Blk_data, Blk_first, Blk_last and Blk_tid SHALL hold stable until Blk_ready.
REQ-023 On the EMIT handshake: if Blk_last, go to IDLE; otherwise clear the buffer, reset the word counter and go to FILL (or PADBLK per REQ-020).
REQ-024 Blk_valid SHALL rise exactly one cycle after the beat that completes or terminates a block is accepted.
REQ-025 Blk_first SHALL be 1 only on the first block of each message.
REQ-026 Throughput SHALL be one input beat per cycle while in IDLE or FILL.

Reset
REQ-027 While ARESET=1, the block SHALL be in IDLE, with S_TREADY=0, Blk_valid=0, Blk_first=0, Blk_last=0, Blk_tid=0, Blk_data=0 and the word counter=0.
REQ-028 A reset asserted mid-message or during EMIT SHALL discard the partial block and any pending block; no block SHALL be emitted for that message.
REQ-029 S_TREADY SHALL go to 1 in the first cycle after ARESET deasserts.

Structure
REQ-030 The following SHALL live in a shared package sha3_pkg, shared with the Keccak core and the output serialiser: the state enum, the RATE_BITS table indexed by TID, the pad constants 0x06 and 0x80, and the 1152 maximum rate width.
REQ-031 Pad insertion (byte index n, rate → padded block) SHALL be one combinational sub-module, sha3_pad_gen, instantiated once.

Verification
REQ-032 Empty message: TID=1, one beat with TKEEP=00 and TLAST → one block; byte0=0x06, byte135=0x80, all others 0; first=last=1.
REQ-033 "abc": TID=1, DATA_WIDTH=16; beats 0x6261 (keep 11), then 0x0063 (keep 01, TLAST) → bytes 61 62 63 06, byte135=0x80; Blk_valid rises one cycle after the second beat.
REQ-034 Exact-rate message: TID=3, 36 full beats of 72 bytes → block 1 holds the data with last=0; block 2 has byte0=0x06, byte71=0x80, first=0, last=1.
REQ-035 0x86 case: TID=1, 67 full beats plus one beat with keep=01 and TLAST (135 bytes) → byte135=0x86, single block.
REQ-036 Backpressure: Blk_ready=0 for 5 cycles in EMIT → Blk_data stable, S_TREADY=0; the handshake completes on cycle 6.
REQ-037 Reset after 10 beats, then the empty message of REQ-032 → exactly one block out, identical to REQ-032.
